// File: rtl/step_motor_move_ctrl.sv
// rtl/step_motor_move_ctrl.sv - step-motor controller for fixed, programmed and continuous moves
// Produces the coil phases directly and keeps a wrapping signed step position.
module step_motor_move_ctrl #(
  parameter int CNT_W          = 7,
  parameter int STEPS_PER_MOVE = 100,
  parameter int POS_W          = 12
) (
  input  logic             pulse,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             move,
  input  logic             dir,
  input  logic             half_step,
  input  logic [CNT_W-1:0] step_count,
  output logic [3:0]       coils,
  output logic             step_en,
  output logic             zero_state,
  output logic [CNT_W-1:0] remaining,
  output logic [POS_W-1:0] position,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, MOVE, RUN} state_t;

  localparam logic [CNT_W-1:0] MOVE_LEN = CNT_W'(STEPS_PER_MOVE);

  state_t     state;
  logic       armed;
  logic [2:0] ph;
  logic       press;
  logic       take_step;
  logic [2:0] ph_delta;
  logic [2:0] ph_next;
  logic [3:0] coil_next;

  // One press event per key-down; armed is simply the previously sampled key level.
  assign press      = ~move & armed;
  assign zero_state = (state == IDLE);

  always_comb begin
    take_step = 1'b0;
    case (state)
      MOVE:    take_step = (mode == 2'b01) || (mode == 2'b11);
      RUN:     take_step = (mode == 2'b10);
      default: take_step = 1'b0;
    endcase
  end

  assign ph_delta = half_step ? 3'd1 : 3'd2;
  assign ph_next  = dir ? ph + ph_delta : ph - ph_delta;

  always_comb begin
    coil_next = 4'b1000;
    case (ph_next)
      3'd0: coil_next = 4'b1000;
      3'd1: coil_next = 4'b1100;
      3'd2: coil_next = 4'b0100;
      3'd3: coil_next = 4'b0110;
      3'd4: coil_next = 4'b0010;
      3'd5: coil_next = 4'b0011;
      3'd6: coil_next = 4'b0001;
      3'd7: coil_next = 4'b1001;
      default: coil_next = 4'b1000;
    endcase
  end

  always_ff @(posedge pulse) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b1;
      ph        <= 3'd0;
      coils     <= 4'b1000;
      position  <= '0;
      remaining <= '0;
      step_en   <= 1'b0;
      done      <= 1'b0;
    end else begin
      armed   <= move;
      step_en <= take_step;
      done    <= 1'b0;

      if (take_step) begin
        ph       <= ph_next;
        coils    <= coil_next;
        position <= dir ? position + POS_W'(1) : position - POS_W'(1);
      end

      case (state)
        IDLE: begin
          if (mode == 2'b10) begin
            state <= RUN;
          end else if (press && mode == 2'b01) begin
            remaining <= MOVE_LEN;
            state     <= MOVE;
          end else if (press && mode == 2'b11 && step_count != '0) begin
            remaining <= step_count;
            state     <= MOVE;
          end
        end
        MOVE: begin
          if (mode == 2'b00 || mode == 2'b10) begin
            remaining <= '0;
            state     <= (mode == 2'b10) ? RUN : IDLE;
          end else begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mode != 2'b10) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_step_motor_move_ctrl.sv
// tb/tb_step_motor_move_ctrl.sv - randomized and directed bench with a behavioural model
module tb_step_motor_move_ctrl;
  localparam int CNT_W = 7;
  localparam int STEPS = 100;
  localparam int POS_W = 12;

  logic             pulse = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             move;
  logic             dir;
  logic             half_step;
  logic [CNT_W-1:0] step_count;
  logic [3:0]       coils;
  logic             step_en;
  logic             zero_state;
  logic [CNT_W-1:0] remaining;
  logic [POS_W-1:0] position;
  logic             done;

  step_motor_move_ctrl #(.CNT_W(CNT_W), .STEPS_PER_MOVE(STEPS), .POS_W(POS_W)) dut (
    .pulse(pulse), .rst(rst), .mode(mode), .move(move), .dir(dir),
    .half_step(half_step), .step_count(step_count), .coils(coils),
    .step_en(step_en), .zero_state(zero_state), .remaining(remaining),
    .position(position), .done(done)
  );

  always #5 pulse = ~pulse;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a counted move is "steps left > 0", continuous rotation is a flag.
  logic [3:0] tbl [8];
  bit m_valid = 0;
  bit m_armed = 1;
  bit m_run = 0;
  int m_left = 0;
  int m_ph = 0;
  int m_pos = 0;
  bit m_step_en = 0;
  bit m_done = 0;

  initial begin
    tbl[0] = 4'b1000; tbl[1] = 4'b1100; tbl[2] = 4'b0100; tbl[3] = 4'b0110;
    tbl[4] = 4'b0010; tbl[5] = 4'b0011; tbl[6] = 4'b0001; tbl[7] = 4'b1001;
  end

  always @(posedge pulse) begin
    bit stp;
    bit prs;
    prs = !move && m_armed;
    m_armed = move;
    m_step_en = 0;
    m_done = 0;
    stp = 0;
    if (rst) begin
      m_valid = 1; m_armed = 1; m_run = 0; m_left = 0; m_ph = 0; m_pos = 0;
    end else begin
      if (m_run) begin
        if (mode == 2'b10) stp = 1; else m_run = 0;
      end else if (m_left > 0) begin
        if (mode == 2'b00) m_left = 0;
        else if (mode == 2'b10) begin m_left = 0; m_run = 1; end
        else begin
          stp = 1;
          m_left = m_left - 1;
          if (m_left == 0) m_done = 1;
        end
      end else begin
        if (mode == 2'b10) m_run = 1;
        else if (prs && mode == 2'b01) m_left = STEPS;
        else if (prs && mode == 2'b11 && step_count != 0) m_left = int'(step_count);
      end
      if (stp) begin
        m_ph = (m_ph + (dir ? 1 : -1) * (half_step ? 1 : 2) + 8) % 8;
        m_pos = m_pos + (dir ? 1 : -1);
        m_step_en = 1;
      end
    end
  end

  always @(negedge pulse) begin
    logic [POS_W-1:0] ep;
    if (m_valid) begin
      ep = POS_W'(m_pos);
      chk("coils", 32'(coils), 32'(tbl[m_ph]));
      chk("step_en", 32'(step_en), 32'(m_step_en));
      chk("done", 32'(done), 32'(m_done));
      chk("zero_state", 32'(zero_state), 32'(!m_run && m_left == 0));
      chk("remaining", 32'(remaining), 32'(m_left));
      chk("position", 32'(position), 32'(ep));
    end
  end

  // Event counters and captures for the directed literal checks.
  int n_step = 0;
  int n_done = 0;
  bit wrap_seen = 0;
  logic [POS_W-1:0] prev_pos = '0;
  logic [3:0] hs_q[$];

  always @(negedge pulse) begin
    if (step_en === 1'b1) begin
      n_step++;
      hs_q.push_back(coils);
    end
    if (done === 1'b1) n_done++;
    if (prev_pos == 12'h7FF && position == 12'h800) wrap_seen = 1;
    prev_pos = position;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge pulse);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press();
    move = 1'b0;
    tick(1);
    move = 1'b1;
    tick(1);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; mode = 2'b00; move = 1'b1; dir = 1'b1; half_step = 1'b0; step_count = '0;
    tick(2);
    chk("rst_coils", 32'(coils), 32'h8);
    chk("rst_pos", 32'(position), 32'h0);
    chk("rst_rem", 32'(remaining), 32'h0);
    chk("rst_zero", 32'(zero_state), 32'h1);
    chk("rst_step_en", 32'(step_en), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Fixed move of 100 full steps forward.
    mode = 2'b01; n_step = 0; n_done = 0;
    press();
    tick(105);
    chk("fix_steps", 32'(n_step), 32'd100);
    chk("fix_done", 32'(n_done), 32'd1);
    chk("fix_pos", 32'(position), 32'd100);
    chk("fix_coils", 32'(coils), 32'h8);
    chk("fix_zero", 32'(zero_state), 32'h1);

    // Held key, zero step_count, press during MOVE.
    mode = 2'b11; step_count = 7'd5; n_step = 0;
    move = 1'b0; tick(20); move = 1'b1; tick(3);
    chk("held_steps", 32'(n_step), 32'd5);
    step_count = 7'd0; n_step = 0;
    press(); tick(5);
    chk("zero_cnt_steps", 32'(n_step), 32'd0);
    chk("zero_cnt_idle", 32'(zero_state), 32'h1);
    step_count = 7'd5; n_step = 0;
    press(); press(); tick(10);
    chk("press_in_move", 32'(n_step), 32'd5);

    // Half-step reverse, 3 steps.
    do_reset();
    dir = 1'b0; half_step = 1'b1; mode = 2'b11; step_count = 7'd3;
    hs_q.delete();
    press(); tick(5);
    chk("hs_count", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() == 3) begin
      chk("hs_c0", 32'(hs_q[0]), 32'h9);
      chk("hs_c1", 32'(hs_q[1]), 32'h1);
      chk("hs_c2", 32'(hs_q[2]), 32'h3);
    end
    chk("hs_pos", 32'(position), 32'hFFD);

    // Abort after 10 steps.
    do_reset();
    dir = 1'b1; half_step = 1'b0; mode = 2'b01; n_step = 0; n_done = 0;
    move = 1'b0; tick(1); move = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick(1);
      if (n_step == 10) hit = 1;
    end
    chk("abort_reach", 32'(hit), 32'h1);
    mode = 2'b00;
    tick(1);
    chk("abort_steps", 32'(n_step), 32'd10);
    chk("abort_rem", 32'(remaining), 32'd0);
    chk("abort_zero", 32'(zero_state), 32'h1);
    chk("abort_done", 32'(n_done), 32'd0);
    chk("abort_coils", 32'(coils), 32'h2);

    // Continuous rotation through the position wrap.
    do_reset();
    dir = 1'b1; half_step = 1'b0; n_step = 0; wrap_seen = 0;
    mode = 2'b10;
    tick(4100);
    chk("run_steps", 32'(n_step), 32'd4099);
    chk("run_wrap", 32'(wrap_seen), 32'h1);
    mode = 2'b01;
    tick(1);
    chk("run_stop_zero", 32'(zero_state), 32'h1);
    chk("run_stop_steps", 32'(n_step), 32'd4099);
    chk("run_pos", 32'(position), 32'h003);

    // Reset in the middle of a move.
    do_reset();
    mode = 2'b01;
    press();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (remaining == 7'd40) hit = 1; else tick(1);
    end
    chk("mid_reach", 32'(hit), 32'h1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_rem", 32'(remaining), 32'h0);
    chk("mid_rst_pos", 32'(position), 32'h0);
    chk("mid_rst_coils", 32'(coils), 32'h8);
    chk("mid_rst_zero", 32'(zero_state), 32'h1);
    chk("mid_rst_step_en", 32'(step_en), 32'h0);
    rst = 1'b0;

    // Randomized operation against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) move = ~move;
      if ($urandom_range(0, 9) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) half_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) step_count = CNT_W'($urandom_range(0, 12));
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
